// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      WAIT_R = 2'd2,
      DONE   = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store enables/replication and access checks from the core
// fields, load extraction/extension from the latched fields.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] rdata,
   output logic        ok,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);

   logic        aligned;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      aligned   = 1'b0;
      be        = 4'b1111;
      wdata_rep = wdata;
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~addr_lo[0];
         2'b10:   aligned = (addr_lo == 2'b00);
         default: aligned = 1'b0;
      endcase
      ok = f3_legal(we, funct3) & aligned;
      if (we) begin
         case (funct3)
            F3_B: begin
               be        = 4'b0001 << addr_lo;
               wdata_rep = {4{wdata[7:0]}};
            end
            F3_H: begin
               be        = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      byte_v    = 8'(rdata >> {ld_addr_lo, 3'b000});
      half_v    = 16'(rdata >> {ld_addr_lo[1], 4'b0000});
      rdata_ext = rdata;
      case (ld_funct3)
         F3_B:    rdata_ext = {{24{byte_v[7]}}, byte_v};
         F3_H:    rdata_ext = {{16{half_v[15]}}, half_v};
         F3_BU:   rdata_ext = {24'd0, byte_v};
         F3_HU:   rdata_ext = {16'd0, half_v};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the core and a ready/rvalid data-memory port.
//  state  | meaning
//  IDLE   | waiting for core_valid; checks legality/alignment, latches access
//  REQ    | mem_req held with latched fields until mem_ready
//  WAIT_R | load accepted, waiting for mem_rvalid
//  DONE   | stall released, core_rdata valid; core_valid ignored
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int WORD_AW = 30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               core_valid,
   input  logic               core_we,
   input  logic [2:0]         core_funct3,
   input  logic [31:0]        core_addr,
   input  logic [31:0]        core_wdata,
   output logic [31:0]        core_rdata,
   output logic               stall,
   output logic               misalign_err,
   output logic               bus_err,
   output logic               mem_req,
   output logic               mem_we,
   output logic [WORD_AW-1:0] mem_addr,
   output logic [3:0]         mem_be,
   output logic [31:0]        mem_wdata,
   input  logic               mem_ready,
   input  logic               mem_rvalid,
   input  logic [31:0]        mem_rdata
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   lsu_state_t         state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [31:0]        rdata_q;
   logic               we_q;
   logic [2:0]         f3_q;
   logic [1:0]         lo_q;
   logic [WORD_AW-1:0] addr_q;
   logic [3:0]         be_q;
   logic [31:0]        wd_q;

   logic        ok, accept, capture, tc;
   logic [3:0]  be_c;
   logic [31:0] wd_c, rdata_ext;

   lsu_lane_align u_align (
      .we         (core_we),
      .funct3     (core_funct3),
      .addr_lo    (core_addr[1:0]),
      .wdata      (core_wdata),
      .ld_funct3  (f3_q),
      .ld_addr_lo (lo_q),
      .rdata      (mem_rdata),
      .ok         (ok),
      .be         (be_c),
      .wdata_rep  (wd_c),
      .rdata_ext  (rdata_ext)
   );

   assign tc = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d      = state_q;
      stall        = 1'b0;
      misalign_err = 1'b0;
      bus_err      = 1'b0;
      mem_req      = 1'b0;
      accept       = 1'b0;
      capture      = 1'b0;
      case (state_q)
         IDLE: begin
            if (core_valid) begin
               if (ok) begin
                  stall   = 1'b1;
                  accept  = 1'b1;
                  state_d = REQ;
               end else begin
                  misalign_err = 1'b1;
               end
            end
         end
         REQ: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            if (mem_ready) begin
               state_d = we_q ? DONE : WAIT_R;
            end else if (tc) begin
               bus_err = 1'b1;
               state_d = DONE;
            end
         end
         WAIT_R: begin
            stall = 1'b1;
            if (mem_rvalid) begin
               capture = 1'b1;
               state_d = DONE;
            end else if (tc) begin
               bus_err = 1'b1;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Everything is forced quiet during reset, including the combinational stall.
      if (reset) begin
         stall        = 1'b0;
         misalign_err = 1'b0;
         bus_err      = 1'b0;
         mem_req      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         lo_q    <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= core_we;
            f3_q    <= core_funct3;
            lo_q    <= core_addr[1:0];
            addr_q  <= core_addr[WORD_AW+1:2];
            be_q    <= core_we ? be_c : 4'b1111;
            wd_q    <= wd_c;
            cnt_q   <= '0;
            rdata_q <= '0;
         end else if (state_q == REQ || state_q == WAIT_R) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (capture) rdata_q <= rdata_ext;
         else if (bus_err) rdata_q <= '0;
      end
   end

   assign mem_we     = mem_req & we_q;
   assign mem_addr   = mem_req ? addr_q : '0;
   assign mem_be     = mem_req ? be_q : '0;
   assign mem_wdata  = mem_req ? wd_q : '0;
   assign core_rdata = reset ? '0 : rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed and random load/store traffic against an arithmetic reference model.
module tb_lsu_mem_ctrl;
   localparam int TIMEOUT = 16;
   localparam int WORD_AW = 30;

   logic clk = 1'b0;
   logic reset;
   logic core_valid, core_we;
   logic [2:0] core_funct3;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic stall, misalign_err, bus_err, mem_req, mem_we;
   logic [WORD_AW-1:0] mem_addr;
   logic [3:0] mem_be;
   logic [31:0] mem_wdata;
   logic mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail = 0;

   lsu_mem_ctrl #(.TIMEOUT(TIMEOUT), .WORD_AW(WORD_AW)) dut (
      .clk(clk), .reset(reset), .core_valid(core_valid), .core_we(core_we),
      .core_funct3(core_funct3), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .stall(stall), .misalign_err(misalign_err),
      .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int m_size(input bit [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit m_ok(input bit we, input bit [2:0] f3, input bit [31:0] a);
      bit legal;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      return legal && ((a % m_size(f3)) == 0);
   endfunction

   function automatic bit [3:0] m_be(input bit we, input bit [2:0] f3, input bit [31:0] a);
      if (!we) return 4'hF;
      case (m_size(f3))
         1: return 4'(1 << (a % 4));
         2: return 4'(3 << (a % 4));
         default: return 4'hF;
      endcase
   endfunction

   function automatic bit [31:0] m_wd(input bit [2:0] f3, input bit [31:0] wd);
      case (m_size(f3))
         1: return (wd & 32'hFF) * 32'h01010101;
         2: return (wd & 32'hFFFF) * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
      bit [31:0] v;
      v = rd >> (8 * (a % 4));
      case (f3)
         3'd0: return ((v & 32'hFF) >= 128) ? (v & 32'hFF) - 32'd256 : (v & 32'hFF);
         3'd1: return ((v & 32'hFFFF) >= 32768) ? (v & 32'hFFFF) - 32'd65536 : (v & 32'hFFFF);
         3'd4: return v & 32'hFF;
         3'd5: return v & 32'hFFFF;
         default: return rd;
      endcase
   endfunction

   task automatic access(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wd, input int rdly, input int vdly,
                         input bit [31:0] rd, input string tag);
      bit ok, done, to;
      int n, m;
      ok = m_ok(we, f3, addr);
      @(posedge clk); #1;
      core_valid = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wd;
      mem_ready = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clk);
      check({tag, ".idle_stall"}, stall, ok);
      check({tag, ".misalign"}, misalign_err, !ok);
      check({tag, ".idle_req"}, mem_req, 0);
      if (!ok) begin
         @(posedge clk); #1;
         core_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
         @(negedge clk);
         check({tag, ".drop_req"}, mem_req, 0);
         check({tag, ".drop_stall"}, stall, 0);
         return;
      end
      n = 0; to = 0; done = 0;
      while (!done) begin
         @(posedge clk); #1;
         mem_ready = (n >= rdly); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
         @(negedge clk);
         check({tag, ".req"}, mem_req, 1);
         check({tag, ".req_stall"}, stall, 1);
         check({tag, ".we"}, mem_we, we);
         check({tag, ".addr"}, mem_addr, addr >> 2);
         check({tag, ".be"}, mem_be, m_be(we, f3, addr));
         check({tag, ".wdata"}, mem_wdata, we ? m_wd(f3, wd) : wd);
         if (mem_ready) done = 1;
         else if (n == TIMEOUT - 1) begin to = 1; done = 1; end
         check({tag, ".req_buserr"}, bus_err, to);
         n++;
      end
      if (!we && !to) begin
         done = 0; m = 0;
         while (!done) begin
            @(posedge clk); #1;
            mem_ready = 1'($urandom_range(0, 1)); mem_rvalid = (m >= vdly);
            mem_rdata = mem_rvalid ? rd : $urandom;
            @(negedge clk);
            check({tag, ".wait_stall"}, stall, 1);
            check({tag, ".wait_req"}, mem_req, 0);
            if (mem_rvalid) done = 1;
            else if (n == TIMEOUT - 1) begin to = 1; done = 1; end
            check({tag, ".wait_buserr"}, bus_err, to);
            n++; m++;
         end
      end
      @(posedge clk); #1;
      mem_ready = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      @(negedge clk);
      check({tag, ".done_stall"}, stall, 0);
      check({tag, ".done_req"}, mem_req, 0);
      check({tag, ".done_buserr"}, bus_err, 0);
      if (!we) check({tag, ".rdata"}, core_rdata, to ? 32'd0 : m_load(f3, addr, rd));
      @(posedge clk); #1;
      core_valid = 1'b0; mem_ready = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({tag, ".gap_stall"}, stall, 0);
      check({tag, ".gap_req"}, mem_req, 0);
   endtask

   initial begin
      bit we;
      bit [2:0] f3;
      bit [31:0] a;
      int rdly, vdly;
      reset = 1'b1; core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b011;
      core_addr = 32'h3; core_wdata = 32'h0; mem_ready = 1'b1; mem_rvalid = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.stall", stall, 0);
      check("rst.misalign", misalign_err, 0);
      check("rst.buserr", bus_err, 0);
      check("rst.req", mem_req, 0);
      check("rst.rdata", core_rdata, 0);
      check("rst.be", mem_be, 0);
      @(posedge clk); #1;
      reset = 1'b0; core_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;

      access(1, 3'd2, 32'h64, 32'h19, 0, 0, 0, "sw");
      access(1, 3'd0, 32'h62, 32'hA5, 0, 0, 0, "sb");
      access(1, 3'd1, 32'h66, 32'h1234_BEEF, 2, 0, 0, "sh");
      access(0, 3'd0, 32'h23, 0, 0, 0, 32'h80FF1234, "lb");
      access(0, 3'd4, 32'h23, 0, 1, 2, 32'h80FF1234, "lbu");
      access(0, 3'd1, 32'h22, 0, 0, 1, 32'h80FF1234, "lh");
      access(0, 3'd5, 32'h22, 0, 0, 0, 32'h80FF1234, "lhu");
      access(0, 3'd1, 32'h21, 0, 0, 0, 0, "lh_mis");
      access(1, 3'd4, 32'h20, 0, 0, 0, 0, "st_ill");
      access(0, 3'd2, 32'h40, 0, 100, 0, 32'h1111_2222, "ld_to_req");
      access(0, 3'd2, 32'h44, 0, 3, 100, 32'h1111_2222, "ld_to_wait");

      // Reset while a load sits in WAIT_R, then a stray rvalid.
      access(0, 3'd2, 32'h48, 0, 0, 0, 32'hCAFE_F00D, "pre_rst");
      @(posedge clk); #1;
      core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'd2; core_addr = 32'h50;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_rvalid = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("mrst.stall", stall, 0);
      check("mrst.req", mem_req, 0);
      check("mrst.rdata", core_rdata, 0);
      check("mrst.addr", mem_addr, 0);
      @(posedge clk); #1;
      reset = 1'b0; core_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("mrst.idle_stall", stall, 0);
      check("mrst.idle_req", mem_req, 0);
      check("mrst.idle_buserr", bus_err, 0);
      check("mrst.idle_mis", misalign_err, 0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      check("mrst.no_capture", core_rdata, 0);

      for (int i = 0; i < 70; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 4) + 1) % 6);
         if (f3 == 3'd3) f3 = 3'd2;
         a = $urandom;
         if ($urandom_range(0, 9) < 7 && f3[1:0] != 2'b11) a = a & ~32'(m_size(f3) - 1);
         rdly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
         vdly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
         access(we, f3, a, $urandom, rdly, vdly, $urandom, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
